pong_game_ctrl: RTL and testbench

Game-flow sequencer for the pong datapath. It owns the ball position and velocity, the serve hand-off, point scoring, inter-point delay and the game-over condition. It is driven by a per-frame tick (vsync falling edge) and by the paddle collision flags from the collision detectors, and it feeds ball_x/ball_y to the ball sprite and collision units.

---
 rtl/pong_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_game_ctrl : serve / play / point / game-over sequencer, owns ball motion
// Rev 1.0
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int B_SPD     = 8,
   parameter int BY_SPD    = 4,
   parameter int BALL_SZ   = 10,
   parameter int SCR_W     = 640,
   parameter int SCR_H     = 480,
   parameter int SRV_XL    = 65,
   parameter int SRV_XR    = 575,
   parameter int SRV_Y     = 240,
   parameter int SCORE_MAX = 9,
   parameter int SRV_DELAY = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame,
   input  logic       p1_srv,
   input  logic       p2_srv,
   input  logic       p1_c,
   input  logic       p2_c,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] side,
   output logic [1:0] state,
   output logic       game_over
);
   typedef enum logic [1:0] {
      ST_SERVE = 2'b00,
      ST_PLAY  = 2'b01,
      ST_POINT = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam int                 CNT_W    = (SRV_DELAY > 1) ? $clog2(SRV_DELAY) : 1;
   localparam logic signed [10:0] XSTEP    = 11'(B_SPD);
   localparam logic signed [10:0] YSTEP    = 11'(BY_SPD);
   localparam logic signed [10:0] X_MAX    = 11'(SCR_W - BALL_SZ);
   localparam logic signed [10:0] Y_MAX    = 11'(SCR_H - BALL_SZ);
   localparam logic [9:0]         XL       = 10'(SRV_XL);
   localparam logic [9:0]         XR       = 10'(SRV_XR);
   localparam logic [8:0]         Y0       = 9'(SRV_Y);
   localparam logic [3:0]         SMAX     = 4'(SCORE_MAX);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SRV_DELAY - 1);

   state_t             st_q, st_d;
   logic [1:0]         side_q, side_d;
   logic [9:0]         bx_q, bx_d;
   logic [8:0]         by_q, by_d;
   logic [3:0]         s1_q, s1_d, s2_q, s2_d;
   logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
   logic               dy_up_q, dy_up_d;
   logic               left_next_q, left_next_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               p1_prev, p2_prev;

   logic               p1_rise, p2_rise;
   logic signed [10:0] bx_s, by_s, bx_step, by_step;
   logic [3:0]         s1_inc, s2_inc;

   assign p1_rise = p1_srv & ~p1_prev;
   assign p2_rise = p2_srv & ~p2_prev;
   assign bx_s    = {1'b0, bx_q};
   assign by_s    = {2'b00, by_q};
   assign bx_step = bx_s + dx_q;
   assign by_step = by_s + dy_q;
   assign s1_inc  = (s1_q >= SMAX) ? SMAX : s1_q + 4'd1;
   assign s2_inc  = (s2_q >= SMAX) ? SMAX : s2_q + 4'd1;

   always_comb begin
      st_d        = st_q;
      side_d      = side_q;
      bx_d        = bx_q;
      by_d        = by_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      dy_up_d     = dy_up_q;
      left_next_d = left_next_q;
      cnt_d       = cnt_q;
      unique case (st_q)
         ST_SERVE: begin
            if ((p1_rise && side_q[1]) || (p2_rise && side_q[0])) begin
               st_d    = ST_PLAY;
               side_d  = 2'b00;
               dx_d    = (p1_rise && side_q[1]) ? XSTEP : -XSTEP;
               dy_d    = dy_up_q ? -YSTEP : YSTEP;
               dy_up_d = ~dy_up_q;
            end
         end
         ST_PLAY: begin
            // Paddle contact only re-aims; the step itself waits for the frame.
            if (p1_c && !p2_c)      dx_d = XSTEP;
            else if (p2_c && !p1_c) dx_d = -XSTEP;
            if (frame) begin
               cnt_d = '0;
               if (dx_q[10] && (bx_s < XSTEP)) begin
                  s2_d        = s2_inc;
                  left_next_d = 1'b1;
                  st_d        = (s2_inc == SMAX) ? ST_OVER : ST_POINT;
               end else if (!dx_q[10] && (dx_q != '0) && (bx_s + XSTEP > X_MAX)) begin
                  s1_d        = s1_inc;
                  left_next_d = 1'b0;
                  st_d        = (s1_inc == SMAX) ? ST_OVER : ST_POINT;
               end else begin
                  bx_d = bx_step[9:0];
               end
               if (dy_q[10]) begin
                  if (by_s < YSTEP) begin
                     by_d = '0;
                     dy_d = YSTEP;
                  end else begin
                     by_d = by_step[8:0];
                  end
               end else if (by_s + YSTEP > Y_MAX) begin
                  by_d = Y_MAX[8:0];
                  dy_d = -YSTEP;
               end else begin
                  by_d = by_step[8:0];
               end
            end
            if (st_d == ST_OVER) begin
               dx_d = '0;
               dy_d = '0;
            end
         end
         ST_POINT: begin
            if (frame) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  st_d  = ST_SERVE;
                  by_d  = Y0;
                  // The player who conceded gets the ball.
                  side_d = left_next_q ? 2'b10 : 2'b01;
                  bx_d   = left_next_q ? XL : XR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_OVER: begin
            if (p1_rise || p2_rise) begin
               s1_d   = '0;
               s2_d   = '0;
               st_d   = ST_SERVE;
               side_d = 2'b01;
               bx_d   = XR;
               by_d   = Y0;
            end
         end
         default: st_d = ST_SERVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q        <= ST_SERVE;
         side_q      <= 2'b01;
         bx_q        <= XR;
         by_q        <= Y0;
         s1_q        <= '0;
         s2_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         dy_up_q     <= 1'b0;
         left_next_q <= 1'b0;
         cnt_q       <= '0;
         p1_prev     <= 1'b0;
         p2_prev     <= 1'b0;
      end else begin
         st_q        <= st_d;
         side_q      <= side_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         dy_up_q     <= dy_up_d;
         left_next_q <= left_next_d;
         cnt_q       <= cnt_d;
         p1_prev     <= p1_srv;
         p2_prev     <= p2_srv;
      end
   end

   assign ball_x    = bx_q;
   assign ball_y    = by_q;
   assign p1_score  = s1_q;
   assign p2_score  = s2_q;
   assign side      = side_q;
   assign state     = st_q;
   assign game_over = (st_q == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl : scoreboard bench for the pong game-flow sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pong_game_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, frame = 1'b0;
   logic       p1_srv = 1'b0, p2_srv = 1'b0, p1_c = 1'b0, p2_c = 1'b0;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [3:0] p1_score, p2_score;
   logic [1:0] side, state;
   logic       game_over;

   pong_game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame(frame), .p1_srv(p1_srv), .p2_srv(p2_srv),
      .p1_c(p1_c), .p2_c(p2_c), .ball_x(ball_x), .ball_y(ball_y),
      .p1_score(p1_score), .p2_score(p2_score), .side(side), .state(state),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic [1:0] sd;
      logic [9:0] bx;
      logic [8:0] by;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       go;
   } snap_t;

   snap_t exp_q[$];
   int    checks = 0, failures = 0;

   // Reference game model, plain integers.
   int m_st, m_sd, m_bx, m_by, m_s1, m_s2, m_dx, m_dy, m_cnt;
   bit m_down, m_left_next, m_p1p, m_p2p;

   task automatic model_clk(input bit rn, input bit fr, input bit s1, input bit s2,
                            input bit c1, input bit c2);
      bit r1, r2;
      int ndx;
      r1 = s1 && !m_p1p;
      r2 = s2 && !m_p2p;
      m_p1p = s1;
      m_p2p = s2;
      if (!rn) begin
         m_st = 0; m_sd = 1; m_bx = 575; m_by = 240; m_s1 = 0; m_s2 = 0;
         m_dx = 0; m_dy = 0; m_down = 1; m_cnt = 0; m_p1p = 0; m_p2p = 0;
         m_left_next = 0;
         return;
      end
      case (m_st)
         0: begin
            if ((r1 && m_sd == 2) || (r2 && m_sd == 1)) begin
               m_dx   = (r1 && m_sd == 2) ? 8 : -8;
               m_st   = 1;
               m_sd   = 0;
               m_dy   = m_down ? 4 : -4;
               m_down = !m_down;
            end
         end
         1: begin
            ndx = m_dx;
            if (c1 && !c2) ndx = 8;
            else if (c2 && !c1) ndx = -8;
            if (fr) begin
               if (m_dx < 0 && m_bx < 8) begin
                  m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
                  m_left_next = 1; m_cnt = 0;
                  m_st = (m_s2 == 9) ? 3 : 2;
               end else if (m_dx > 0 && m_bx + 8 > 630) begin
                  m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
                  m_left_next = 0; m_cnt = 0;
                  m_st = (m_s1 == 9) ? 3 : 2;
               end else begin
                  m_bx = m_bx + m_dx;
               end
               if (m_dy < 0) begin
                  if (m_by < 4) begin m_by = 0; m_dy = 4; end
                  else m_by = m_by + m_dy;
               end else if (m_by + 4 > 470) begin
                  m_by = 470; m_dy = -4;
               end else begin
                  m_by = m_by + m_dy;
               end
            end
            m_dx = ndx;
            if (m_st == 3) begin m_dx = 0; m_dy = 0; end
         end
         2: begin
            if (fr) begin
               if (m_cnt == 59) begin
                  m_cnt = 0; m_st = 0; m_by = 240;
                  m_sd  = m_left_next ? 2 : 1;
                  m_bx  = m_left_next ? 65 : 575;
               end else begin
                  m_cnt++;
               end
            end
         end
         default: begin
            if (r1 || r2) begin
               m_s1 = 0; m_s2 = 0; m_st = 0; m_sd = 1; m_bx = 575; m_by = 240;
            end
         end
      endcase
   endtask

   function automatic snap_t mk(input int st, input int sd, input int bx, input int by,
                                input int s1, input int s2);
      snap_t s;
      s.st = st[1:0]; s.sd = sd[1:0]; s.bx = bx[9:0]; s.by = by[8:0];
      s.s1 = s1[3:0]; s.s2 = s2[3:0]; s.go = (st == 3);
      return s;
   endfunction

   function automatic snap_t model_snap();
      return mk(m_st, m_sd, m_bx, m_by, m_s1, m_s2);
   endfunction

   function automatic snap_t dut_snap();
      return {state, side, ball_x, ball_y, p1_score, p2_score, game_over};
   endfunction

   task automatic tick(input bit fr = 0, input bit c1 = 0, input bit c2 = 0, input bit rn = 1);
      frame = fr; p1_c = c1; p2_c = c2; rst_n = rn;
      model_clk(rn, fr, p1_srv, p2_srv, c1, c2);
      @(posedge clk);
      #1;
   endtask

   // Keeps a rally alive by hitting the paddles before the ball can escape.
   task automatic rally_frame();
      if (m_st == 1 && m_dx > 0 && m_bx >= 600) tick(0, 0, 1);
      else if (m_st == 1 && m_dx < 0 && m_bx <= 40) tick(0, 1, 0);
      tick(1);
   endtask

   task automatic test_reset();
      snap_t g, e;
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      tick();
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      repeat (3) tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL serve_hold got=%h exp=%h", g, e); end
   endtask

   task automatic test_serve();
      snap_t g, e;
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      p1_srv = 1; tick();
      p1_srv = 0; tick();
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL wrong_side_serve got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 575, 240, 0, 0));
      p2_srv = 1; tick();
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL serve_start got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 551, 252, 0, 0));
      repeat (3) tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL serve_3frames got=%h exp=%h", g, e); end
      p2_srv = 0; tick();
   endtask

   task automatic test_collision();
      snap_t g, e;
      exp_q.push_back(mk(1, 0, 543, 256, 0, 0));
      tick(0, 1, 1);
      tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL both_paddles got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 551, 260, 0, 0));
      tick(0, 1, 0);
      tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL left_paddle got=%h exp=%h", g, e); end
   endtask

   task automatic test_wall();
      snap_t g, e;
      int    n;
      n = 0;
      while (m_by != 470 && n < 300) begin rally_frame(); n++; end
      checks++;
      if (ball_y !== 9'd470) begin failures++; $display("FAIL bottom_clamp got=%0d exp=470", ball_y); end
      n = 0;
      while (!(m_by == 2 && m_dy < 0) && n < 300) begin rally_frame(); n++; end
      exp_q.push_back(model_snap());
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e || ball_y !== 9'd2) begin
         failures++; $display("FAIL near_top got=%h exp=%h y=%0d", g, e, ball_y);
      end
      rally_frame();
      checks++;
      if (ball_y !== 9'd0) begin failures++; $display("FAIL top_clamp got=%0d exp=0", ball_y); end
      rally_frame();
      checks++;
      if (ball_y !== 9'd4) begin failures++; $display("FAIL top_bounce got=%0d exp=4", ball_y); end
   endtask

   task automatic test_miss_left();
      snap_t g, e;
      int    n;
      if (m_dx > 0) tick(0, 0, 1);
      n = 0;
      while (m_st == 1 && n < 200) begin tick(1); n++; end
      exp_q.push_back(model_snap());
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e || state !== 2'b10 || p2_score !== 4'd1 || ball_x !== 10'd7) begin
         failures++; $display("FAIL miss_left got=%h exp=%h", g, e);
      end
      p1_srv = 1; tick();
      p1_srv = 0; tick();
      repeat (59) tick(1);
      checks++;
      if (state !== 2'b10) begin failures++; $display("FAIL point_hold got=%0d exp=2", state); end
      exp_q.push_back(mk(0, 2, 65, 240, 0, 1));
      tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL point_to_serve got=%h exp=%h", g, e); end
   endtask

   task automatic test_game_over();
      snap_t g, e;
      int    n, pts;
      pts = 0;
      while (m_s1 < 9 && pts < 12) begin
         if (m_sd == 2) begin
            p1_srv = 1; tick();
            p1_srv = 0; tick();
         end else begin
            p2_srv = 1; tick();
            p2_srv = 0; tick(0, 1, 0);
         end
         n = 0;
         while (m_st == 1 && n < 200) begin tick(1); n++; end
         exp_q.push_back(model_snap());
         g = dut_snap(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin failures++; $display("FAIL right_miss_%0d got=%h exp=%h", pts, g, e); end
         n = 0;
         while (m_st == 2 && n < 70) begin tick(1); n++; end
         pts++;
      end
      checks++;
      if (state !== 2'b11 || game_over !== 1'b1 || p1_score !== 4'd9 || p2_score !== 4'd1) begin
         failures++;
         $display("FAIL game_over got=st%0d go%0d s%0d/%0d exp=st3 go1 s9/1",
                  state, game_over, p1_score, p2_score);
      end
      exp_q.push_back(model_snap());
      repeat (3) tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL over_frozen got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      p2_srv = 1; tick();
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL over_restart got=%h exp=%h", g, e); end
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      repeat (3) tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL restart_no_serve got=%h exp=%h", g, e); end
      p2_srv = 0; tick();
   endtask

   task automatic test_reset_mid_play();
      snap_t g, e;
      int    n;
      p2_srv = 1; tick();
      p2_srv = 0; tick();
      n = 0;
      while (m_st == 1 && n < 200) begin tick(1); n++; end
      n = 0;
      while (m_st == 2 && n < 70) begin tick(1); n++; end
      p1_srv = 1; tick();
      p1_srv = 0; tick();
      repeat (3) tick(1);
      exp_q.push_back(mk(0, 1, 575, 240, 0, 0));
      tick(1, 1, 0, 0);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset_mid_play got=%h exp=%h", g, e); end
      exp_q.push_back(mk(1, 0, 567, 244, 0, 0));
      p2_srv = 1; tick();
      p2_srv = 0; tick(1);
      g = dut_snap(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL serve_after_reset got=%h exp=%h", g, e); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_collision();
      test_wall();
      test_miss_left();
      test_game_over();
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
